// File: rtl/muldiv_iter.sv
// Iterative signed multiplier / divider.
// One iteration per clock: radix-2 Booth for multiply, restoring division on
// operand magnitudes for divide. A start is taken only in IDLE. Busy covers
// the WIDTH iteration cycles, DONE is a one-cycle settling state, and the
// result-valid strobe is registered out of DONE, so it rises WIDTH+1 edges
// after the accepting edge.
//
//   state | meaning
//   IDLE  | waiting for ctrl_MULT / ctrl_DIV, starts ignored elsewhere
//   MUL   | Booth iterations, busy high
//   DIV   | restoring-divide iterations, busy high
//   DONE  | result/exception just loaded; next edge raises RDY and returns to IDLE
module muldiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  // Upper WIDTH+1 bits: Booth partial product / division remainder.
  // Lower WIDTH bits: multiplier being shifted out / dividend becoming quotient.
  logic [2*WIDTH:0]   acc_q;
  // Multiplicand sign-extended, or divisor magnitude zero-extended.
  logic [WIDTH:0]     opb_q;
  logic               booth_q;
  logic               div_neg_q;
  logic               div_zero_q;
  logic               div_ovf_q;
  logic [WIDTH-1:0]   result_q;
  logic               exc_q;
  logic               rdy_q;
  logic               busy_q;

  logic [WIDTH:0]     booth_hi;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   mul_acc_d;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic [WIDTH:0]     div_rem;
  logic [2*WIDTH:0]   div_acc_d;
  logic [WIDTH-1:0]   mul_res_d;
  logic               mul_exc_d;
  logic [WIDTH-1:0]   div_quo;
  logic [WIDTH-1:0]   div_res_d;
  logic               div_exc_d;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               last_iter;

  // Single iteration datapaths for both operations plus final result shaping.
  always_comb begin
    booth_hi  = acc_q[2*WIDTH:WIDTH];
    booth_sum = booth_hi;
    case ({acc_q[0], booth_q})
      2'b10:   booth_sum = booth_hi - opb_q;
      2'b01:   booth_sum = booth_hi + opb_q;
      default: booth_sum = booth_hi;
    endcase
    // Arithmetic shift right of {partial product, multiplier}.
    mul_acc_d = {booth_sum[WIDTH], booth_sum, acc_q[WIDTH-1:1]};

    // Remainder stays below the divisor, so the shifted value fits WIDTH+1 bits.
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = (div_shift >= opb_q);
    div_rem   = div_ge ? (div_shift - opb_q) : div_shift;
    div_acc_d = {div_rem, acc_q[WIDTH-2:0], div_ge};

    // The full product always fits 2*WIDTH bits; overflow means the high half
    // is not a sign extension of the low word.
    mul_res_d = mul_acc_d[WIDTH-1:0];
    mul_exc_d = (mul_acc_d[2*WIDTH:WIDTH] != {(WIDTH+1){mul_acc_d[WIDTH-1]}});

    // Most-negative / -1 gives a positive 2^(WIDTH-1) magnitude whose bit
    // pattern is already the most-negative value, so only the flag is needed.
    div_quo   = div_acc_d[WIDTH-1:0];
    div_res_d = div_zero_q ? '0 : (div_neg_q ? ('0 - div_quo) : div_quo);
    div_exc_d = div_zero_q | div_ovf_q;

    mag_a     = data_operandA[WIDTH-1] ? ('0 - data_operandA) : data_operandA;
    mag_b     = data_operandB[WIDTH-1] ? ('0 - data_operandB) : data_operandB;
    last_iter = (cnt_q == CW'(WIDTH - 1));
  end

  // Sequencer: operand capture, iteration, result load and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      opb_q      <= '0;
      booth_q    <= 1'b0;
      div_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
      div_ovf_q  <= 1'b0;
      result_q   <= '0;
      exc_q      <= 1'b0;
      rdy_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (ctrl_MULT) begin
            state_q <= MUL;
            busy_q  <= 1'b1;
            acc_q   <= {{(WIDTH+1){1'b0}}, data_operandA};
            opb_q   <= {data_operandB[WIDTH-1], data_operandB};
            booth_q <= 1'b0;
          end else if (ctrl_DIV) begin
            state_q    <= DIV;
            busy_q     <= 1'b1;
            acc_q      <= {{(WIDTH+1){1'b0}}, mag_a};
            opb_q      <= {1'b0, mag_b};
            div_neg_q  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero_q <= (data_operandB == '0);
            div_ovf_q  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                          (data_operandB == '1);
          end
        end
        MUL: begin
          acc_q   <= mul_acc_d;
          booth_q <= acc_q[0];
          cnt_q   <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            result_q <= mul_res_d;
            exc_q    <= mul_exc_d;
          end
        end
        DIV: begin
          acc_q <= div_acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            result_q <= div_res_d;
            exc_q    <= div_exc_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Randomized self-checking bench for muldiv_iter (WIDTH = 32).
module tb_muldiv_iter;

  logic        clock;
  logic        reset;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference: exact integer arithmetic on signed 32-bit operands.
  function automatic void model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e);
    longint p;
    int     q;
    if (is_mul) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      r = 32'd0;
      e = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      q = $signed(a) / $signed(b);
      r = q;
      e = 1'b0;
    end
  endfunction

  function automatic logic [31:0] rand_operand();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0: v = $urandom;
      1: v = 32'($urandom_range(0, 63)) - 32'd32;
      2: case ($urandom_range(0, 3))
           0: v = 32'h8000_0000;
           1: v = 32'h7FFF_FFFF;
           2: v = 32'hFFFF_FFFF;
           default: v = 32'd0;
         endcase
      default: begin
        v = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) v = -v;
      end
    endcase
    return v;
  endfunction

  // Starts one operation, scrambles the inputs after acceptance, and waits
  // (bounded) for the RDY strobe. lat = edges after the accepting edge, -1 on timeout.
  task automatic run_op(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic exc,
                        output int lat, output int busy_n);
    @(negedge clock);
    ctrl_MULT = is_mul;
    ctrl_DIV  = !is_mul;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    lat    = 0;
    busy_n = busy ? 1 : 0;
    res    = 'x;
    exc    = 1'bx;
    while (!data_resultRDY && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (busy) busy_n++;
    end
    if (data_resultRDY) begin
      res = data_result;
      exc = data_exception;
    end else begin
      lat = -1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL reset_outputs got res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_directed();
    bit          op [9];
    logic [31:0] va [9];
    logic [31:0] vb [9];
    logic [31:0] er [9];
    logic        ee [9];
    logic [31:0] res;
    logic        exc;
    int          lat, bn;
    op = '{1, 1, 1, 0, 0, 0, 0, 1, 1};
    va = '{32'd7, 32'h0001_0000, 32'h7FFF_FFFF, 32'hFFFF_FFF9, 32'd100, 32'd5,
           32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
    vb = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1, 32'd2, 32'hFFFF_FFF9, 32'd0,
           32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
    er = '{32'hFFFF_FFEB, 32'h0, 32'h7FFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFF2, 32'h0,
           32'h8000_0000, 32'h0, 32'h8000_0000};
    ee = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_op(op[i], va[i], vb[i], res, exc, lat, bn);
      checks++;
      if (res !== er[i] || exc !== ee[i]) begin
        errors++;
        $display("FAIL directed_%0d got res=%h exc=%b want res=%h exc=%b", i, res, exc, er[i], ee[i]);
      end
      checks++;
      if (lat !== 33) begin
        errors++;
        $display("FAIL directed_latency_%0d got %0d want 33", i, lat);
      end
      checks++;
      if (bn !== 32) begin
        errors++;
        $display("FAIL directed_busy_cycles_%0d got %0d want 32", i, bn);
      end
    end
  endtask

  task automatic test_random(input int n);
    logic [31:0] a, b, res, er;
    logic        exc, ee;
    bit          is_mul;
    int          lat, bn;
    for (int i = 0; i < n; i++) begin
      is_mul = ($urandom_range(0, 1) == 1);
      a = rand_operand();
      b = rand_operand();
      model(is_mul, a, b, er, ee);
      run_op(is_mul, a, b, res, exc, lat, bn);
      checks++;
      if (res !== er || exc !== ee || lat !== 33) begin
        errors++;
        $display("FAIL random_%s a=%h b=%h got res=%h exc=%b lat=%0d want res=%h exc=%b lat=33",
                 is_mul ? "mul" : "div", a, b, res, exc, lat, er, ee);
      end
    end
  endtask

  // Simultaneous start, then start pulses during iteration and during DONE.
  task automatic test_ignore_ctrl();
    logic [31:0] a, b, er, res;
    logic        ee, exc;
    int          lat, rdy_n, first_rdy, busy_late;
    a = 32'd12345;
    b = 32'hFFFF_FD4A;
    model(1'b1, a, b, er, ee);
    @(negedge clock);
    ctrl_MULT = 1'b1;
    ctrl_DIV  = 1'b1;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock); #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    rdy_n = 0; first_rdy = -1; busy_late = 0;
    res = 'x; exc = 1'bx;
    for (lat = 1; lat <= 45; lat++) begin
      @(posedge clock); #1;
      if (data_resultRDY) begin
        rdy_n++;
        if (first_rdy < 0) begin
          first_rdy = lat;
          res = data_result;
          exc = data_exception;
        end
      end
      if (busy && lat > 32) busy_late++;
      ctrl_DIV = 1'b0;
      if (lat == 5) begin
        ctrl_DIV = 1'b1;
        data_operandA = 32'd99;
        data_operandB = 32'd3;
      end
      if (lat == 32) ctrl_DIV = 1'b1;
    end
    ctrl_DIV = 1'b0;
    checks++;
    if (res !== er || exc !== ee) begin
      errors++;
      $display("FAIL ignore_result got res=%h exc=%b want res=%h exc=%b", res, exc, er, ee);
    end
    checks++;
    if (rdy_n !== 1 || first_rdy !== 33) begin
      errors++;
      $display("FAIL ignore_rdy got pulses=%0d at=%0d want pulses=1 at=33", rdy_n, first_rdy);
    end
    checks++;
    if (busy_late !== 0) begin
      errors++;
      $display("FAIL ignore_no_restart got busy_cycles=%0d want 0", busy_late);
    end
  endtask

  task automatic test_reset_abort();
    logic [31:0] res;
    logic        exc;
    int          lat, bn, rdy_seen, busy_seen;
    @(negedge clock);
    ctrl_DIV = 1'b1;
    data_operandA = 32'hFFFF_FC18;
    data_operandB = 32'd7;
    @(posedge clock); #1;
    ctrl_DIV = 1'b0;
    repeat (10) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'd0) begin
      errors++;
      $display("FAIL abort_outputs got res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    rdy_seen = 0; busy_seen = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (data_resultRDY) rdy_seen++;
      if (busy) busy_seen++;
    end
    checks++;
    if (rdy_seen !== 0 || busy_seen !== 0) begin
      errors++;
      $display("FAIL abort_quiet got rdy=%0d busy=%0d want 0 0", rdy_seen, busy_seen);
    end
    run_op(1'b1, 32'd3, 32'd4, res, exc, lat, bn);
    checks++;
    if (res !== 32'h0000_000C || exc !== 1'b0 || lat !== 33) begin
      errors++;
      $display("FAIL abort_restart got res=%h exc=%b lat=%0d want res=0000000c exc=0 lat=33", res, exc, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] a [3];
    logic [31:0] b [3];
    bit          m [3];
    logic [31:0] res, er;
    logic        exc, ee;
    int          lat, bn;
    for (int i = 0; i < 3; i++) begin
      m[i] = (i != 1);
      a[i] = rand_operand();
      b[i] = rand_operand();
    end
    for (int i = 0; i < 3; i++) begin
      if (i == 2) @(posedge clock);
      model(m[i], a[i], b[i], er, ee);
      run_op(m[i], a[i], b[i], res, exc, lat, bn);
      checks++;
      if (res !== er || exc !== ee || lat !== 33) begin
        errors++;
        $display("FAIL back_to_back_%0d got res=%h exc=%b lat=%0d want res=%h exc=%b lat=33",
                 i, res, exc, lat, er, ee);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(40);
    test_ignore_ctrl();
    test_reset_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_iter.md
MULDIV_ITER -- requirements
Module: muldiv_iter

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width; even, >= 4.
REQ-002 SHALL have port: clock  input  1  master clock, all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset (0 = asserted).
REQ-004 SHALL have port: ctrl_MULT  input  1  start signed multiply, sampled on rising edge.
REQ-005 SHALL have port: ctrl_DIV  input  1  start signed divide, sampled on rising edge.
REQ-006 SHALL have port: data_operandA  input  WIDTH  multiplicand / dividend.
REQ-007 SHALL have port: data_operandB  input  WIDTH  multiplier / divisor.
REQ-008 SHALL have port: data_result  output  WIDTH  product low word / quotient.
REQ-009 SHALL have port: data_exception  output  1  overflow or divide-by-zero flag.
REQ-010 SHALL have port: data_resultRDY  output  1  one-cycle result-valid strobe.
REQ-011 SHALL have port: busy  output  1  high while in MUL or DIV state.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; reset state IDLE.
REQ-013 IDLE: rising edge with ctrl_MULT=1 -> MUL; with ctrl_DIV=1 (ctrl_MULT=0) -> DIV; iteration counter cleared to 0.
REQ-014 Simultaneous ctrl_MULT and ctrl_DIV in IDLE: SHALL start multiply only.
REQ-015 Operands SHALL be captured only on the accepting edge; later input changes SHALL have no effect on the result.
REQ-016 ctrl_MULT/ctrl_DIV SHALL be ignored in MUL, DIV and DONE (no restart, no queueing).
REQ-017 MUL/DIV: SHALL perform exactly one iteration per edge, counter +1; after WIDTH iterations SHALL enter DONE.
REQ-018 Multiply: radix-2 Booth on 2*WIDTH+1-bit accumulator, signed two's complement.
REQ-019 Divide: restoring/non-restoring on operand magnitudes; quotient sign = signA XOR signB; truncation toward zero; remainder discarded.
REQ-020 DONE: data_resultRDY=1 for exactly one cycle, then IDLE unconditionally.
REQ-021 Latency: RDY high in the cycle following the (WIDTH+1)th rising edge after the accepting edge (33 edges for WIDTH=32).
REQ-022 data_result and data_exception SHALL be updated on entry to DONE and held stable until the next DONE entry or reset.
REQ-023 Multiply exception: SHALL be 1 iff the 2*WIDTH-bit product is not the sign extension of its low WIDTH bits; data_result = low WIDTH bits regardless.
REQ-024 Divide by zero: data_result = 0, data_exception = 1, full WIDTH-iteration latency retained.
REQ-025 Divide of most-negative by -1: data_result = most-negative value, data_exception = 1.
REQ-026 busy SHALL be 1 in MUL and DIV, 0 in IDLE and DONE.
REQ-027 Back-to-back: start asserted in the cycle after RDY (IDLE) SHALL be accepted.

Reset
REQ-028 reset=0 SHALL immediately (asynchronously) force IDLE, counter 0, data_result 0, data_exception 0, data_resultRDY 0, busy 0.
REQ-029 Reset during MUL/DIV SHALL abort the operation with no RDY pulse; the first edge after release with a start asserted SHALL begin a fresh operation.

Verification
REQ-030 MULT A=7, B=-3 -> data_result 0xFFFFFFEB, exception 0, RDY exactly 33 edges after start, busy high for 32 cycles.
REQ-031 MULT A=0x00010000, B=0x00010000 -> data_result 0x00000000, exception 1; A=0x7FFFFFFF, B=1 -> 0x7FFFFFFF, exception 0.
REQ-032 DIV A=-7, B=2 -> 0xFFFFFFFD, exception 0; DIV A=100, B=-7 -> 0xFFFFFFF2, exception 0.
REQ-033 DIV A=5, B=0 -> 0x00000000, exception 1; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000, exception 1.
REQ-034 MULT start with ctrl_DIV also high, then pulse ctrl_DIV at iteration 5 with changed operands -> single multiply result of original operands, one RDY pulse only.
REQ-035 Reset asserted at iteration 10 of a DIV -> all outputs 0 immediately, no RDY; MULT 3*4 after release -> 0x0000000C after 33 edges.
